btn_conditioner: RTL and testbench

Conditions the raw push-button pin for downstream consumers such as the long-press toggle stage. It synchronises the asynchronous pin, debounces it with a counter-based state machine, and normalises polarity. It delivers a clean active-high level plus single-cycle press, release and double-click pulses. It sits directly between the board pin and any timing/toggle logic, whose BTN input takes this block's BTN_CLEAN.

---
 rtl/btn_conditioner_pkg.sv | 22 ++
 rtl/btn_conditioner_sync_2ff.sv | 27 ++
 rtl/btn_conditioner.sv | 151 +++++++++++++++
 tb/tb_btn_conditioner.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM encodings and default timing.
// The toggle stage downstream derives its timing from the same CLK_FREQ.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_CLK_FREQ = 1_000;
  localparam int DEF_CNT_BITS = 24;
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_DOUBLE_MS = 300;

  // Integer-kHz clocks only; gives 20/300 cycles at 1 kHz and 240k/3.6M at 12 MHz.
  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_conditioner_sync_2ff.sv
// Two-flop synchroniser with an asynchronous reset to a chosen idle level,
// so reset release never presents a false edge to the logic behind it.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises, debounces and polarity-normalises a raw button pin; emits a clean
// level plus single-cycle press, release and double-click pulses (all registered).
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int CLK_FREQ        = DEF_CLK_FREQ,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ, DEF_DEBOUNCE_MS),
  parameter int DOUBLE_GAP      = ms_to_cycles(CLK_FREQ, DEF_DOUBLE_MS),
  parameter int CNT_BITS        = DEF_CNT_BITS,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic BTN_CLEAN,
  output logic PRESS,
  output logic RELEASE,
  output logic DOUBLE
);

  localparam logic [CNT_BITS-1:0] CNT_ONE  = 1;
  localparam logic [CNT_BITS-1:0] DEB_MAX  = CNT_BITS'(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] GAP_LAST = CNT_BITS'((DOUBLE_GAP > 0) ? DOUBLE_GAP - 1 : 0);

  logic sync_w;
  logic p;

  sync_2ff #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   (BTN),
    .q_o   (sync_w)
  );

  assign p = sync_w ^ ACTIVE_LOW;

  btn_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] gap_q, gap_d;
  logic                armed_q, armed_d;
  logic                dbl_held_q, dbl_held_d;
  logic                clean_q, clean_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                double_q, double_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      armed_q    <= 1'b0;
      dbl_held_q <= 1'b0;
      clean_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      double_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      armed_q    <= armed_d;
      dbl_held_q <= dbl_held_d;
      clean_q    <= clean_d;
      press_q    <= press_d;
      release_q  <= release_d;
      double_q   <= double_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!p) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_MAX) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!p) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_RELEASE_WAIT: begin
        if (p) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_MAX) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    clean_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
  end

  // dbl_held remembers that the current press was a double, so its release
  // does not re-arm the window (a triple click yields one DOUBLE).
  always_comb begin
    gap_d      = gap_q;
    armed_d    = armed_q;
    dbl_held_d = dbl_held_q;
    double_d   = 1'b0;
    if (press_d) begin
      double_d   = armed_q;
      dbl_held_d = armed_q;
      armed_d    = 1'b0;
    end else if (release_d) begin
      armed_d    = ~dbl_held_q;
      dbl_held_d = 1'b0;
      gap_d      = '0;
    end else if (armed_q) begin
      gap_d = gap_q + CNT_ONE;
      if (gap_q >= GAP_LAST) begin
        armed_d = 1'b0;
      end
    end
  end

  assign BTN_CLEAN = clean_q;
  assign PRESS     = press_q;
  assign RELEASE   = release_q;
  assign DOUBLE    = double_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scenario bench for btn_conditioner: expected pulses are queued with their cycle
// when stimulus is driven; a negedge monitor pops and compares them as they appear.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic btn_pol;
  logic btn_clean, press, rel, dbl;
  logic clean_p, press_p, rel_p, dbl_p;

  always #5 clk = ~clk;

  btn_conditioner #(
    .CLK_FREQ(1_000), .DEBOUNCE_CYCLES(20), .DOUBLE_GAP(300), .CNT_BITS(24), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .BTN(btn),
    .BTN_CLEAN(btn_clean), .PRESS(press), .RELEASE(rel), .DOUBLE(dbl)
  );

  btn_conditioner #(
    .CLK_FREQ(1_000), .DEBOUNCE_CYCLES(20), .DOUBLE_GAP(300), .CNT_BITS(24), .ACTIVE_LOW(1'b0)
  ) u_dut_pol (
    .CLK(clk), .RST_N(rst_n), .BTN(btn_pol),
    .BTN_CLEAN(clean_p), .PRESS(press_p), .RELEASE(rel_p), .DOUBLE(dbl_p)
  );

  typedef struct {
    int   cyc;
    logic press;
    logic rel;
    logic dbl;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  dbl_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_pulse cycle=%0d got none, expected press=%b release=%b double=%b",
               e.cyc, e.press, e.rel, e.dbl);
    end
    if (dbl) dbl_seen++;
    if (press || rel || dbl) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        failures++;
        $display("FAIL unexpected_pulse cycle=%0d got press=%b release=%b double=%b, expected none",
                 cyc, press, rel, dbl);
      end else begin
        e = exp_q.pop_front();
        if ({press, rel, dbl} !== {e.press, e.rel, e.dbl}) begin
          failures++;
          $display("FAIL pulse_kind cycle=%0d got press=%b release=%b double=%b, expected %b %b %b",
                   cyc, press, rel, dbl, e.press, e.rel, e.dbl);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw edge driven at a negedge when cyc==t lands as a pulse observed at cyc==t+23.
  task automatic push_ev(input int t, input logic p, input logic r, input logic d);
    ev_t e;
    e.cyc = t + 23;
    e.press = p;
    e.rel = r;
    e.dbl = d;
    exp_q.push_back(e);
  endtask

  task automatic click(input int gap_before, input logic exp_dbl);
    step(gap_before);
    btn = 1'b0;
    push_ev(cyc, 1'b1, 1'b0, exp_dbl);
    step(40);
    btn = 1'b1;
    push_ev(cyc, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    int errs;
    rst_n = 1'b0;
    btn = 1'b1;
    btn_pol = 1'b0;
    step(3);
    checks++;
    if ({btn_clean, press, rel, dbl} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0000", {btn_clean, press, rel, dbl});
    end
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if ({btn_clean, press, rel, dbl, clean_p, press_p, rel_p, dbl_p} !== 8'h00) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL reset_release_quiet got=%0d active cycles expected=0", errs);
    end
  endtask

  task automatic test_clean_press();
    int t;
    t = cyc;
    btn = 1'b0;
    push_ev(t, 1'b1, 1'b0, 1'b0);
    step(22);
    checks++;
    if (btn_clean !== 1'b0) begin
      failures++;
      $display("FAIL clean_before_accept got=%b expected=0", btn_clean);
    end
    step(1);
    checks++;
    if (btn_clean !== 1'b1) begin
      failures++;
      $display("FAIL clean_rise got=%b expected=1", btn_clean);
    end
    step(77);
    btn = 1'b1;
    push_ev(cyc, 1'b0, 1'b1, 1'b0);
    step(22);
    checks++;
    if (btn_clean !== 1'b1) begin
      failures++;
      $display("FAIL clean_before_release got=%b expected=1", btn_clean);
    end
    step(1);
    checks++;
    if (btn_clean !== 1'b0) begin
      failures++;
      $display("FAIL clean_fall got=%b expected=0", btn_clean);
    end
    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL clean_press_pending got=%0d expected=0", exp_q.size());
    end
    step(350);
  endtask

  task automatic test_bounce();
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      btn = 1'b0;
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (btn_clean !== 1'b0) errs++;
      end
      btn = 1'b1;
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (btn_clean !== 1'b0) errs++;
      end
    end
    for (int j = 0; j < 30; j++) begin
      step(1);
      if (btn_clean !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL bounce_clean got=%0d high cycles expected=0", errs);
    end
    btn = 1'b0;
    push_ev(cyc, 1'b1, 1'b0, 1'b0);
    step(25);
    btn = 1'b1;
    push_ev(cyc, 1'b0, 1'b1, 1'b0);
    step(30);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_pending got=%0d expected=0", exp_q.size());
    end
    step(350);
  endtask

  task automatic test_double();
    int d0;
    d0 = dbl_seen;
    click(10, 1'b0);
    click(150, 1'b1);
    click(400, 1'b0);
    click(301, 1'b0);
    click(300, 1'b1);
    step(40);
    checks++;
    if (exp_q.size() != 0 || dbl_seen - d0 != 2) begin
      failures++;
      $display("FAIL double_window got pending=%0d doubles=%0d expected pending=0 doubles=2",
               exp_q.size(), dbl_seen - d0);
    end
    step(350);
  endtask

  task automatic test_triple();
    int d0;
    d0 = dbl_seen;
    click(10, 1'b0);
    click(100, 1'b1);
    click(100, 1'b0);
    step(40);
    checks++;
    if (dbl_seen - d0 != 1) begin
      failures++;
      $display("FAIL triple_click_doubles got=%0d expected=1", dbl_seen - d0);
    end
    step(350);
  endtask

  task automatic test_reset_mid_press();
    btn = 1'b0;
    push_ev(cyc, 1'b1, 1'b0, 1'b0);
    step(30);
    checks++;
    if (btn_clean !== 1'b1) begin
      failures++;
      $display("FAIL mid_press_held got=%b expected=1", btn_clean);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_clean !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_clean got=%b expected=0", btn_clean);
    end
    step(3);
    checks++;
    if ({btn_clean, press, rel, dbl} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold_outputs got=%b expected=0000", {btn_clean, press, rel, dbl});
    end
    rst_n = 1'b1;
    push_ev(cyc, 1'b1, 1'b0, 1'b0);
    step(30);
    checks++;
    if (btn_clean !== 1'b1) begin
      failures++;
      $display("FAIL repress_after_reset got=%b expected=1", btn_clean);
    end
    btn = 1'b1;
    push_ev(cyc, 1'b0, 1'b1, 1'b0);
    step(30);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_press_pending got=%0d expected=0", exp_q.size());
    end
    step(350);
  endtask

  task automatic test_polarity();
    int t;
    int pcount;
    int pcyc;
    int dcount;
    t = cyc;
    pcount = 0;
    pcyc = -1;
    dcount = 0;
    btn_pol = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (press_p) begin
        pcount++;
        pcyc = cyc;
      end
      if (dbl_p || rel_p) dcount++;
    end
    checks++;
    if (pcount != 1 || pcyc != t + 23) begin
      failures++;
      $display("FAIL polarity_press got count=%0d at=%0d expected count=1 at=%0d", pcount, pcyc, t + 23);
    end
    checks++;
    if (clean_p !== 1'b1 || dcount != 0) begin
      failures++;
      $display("FAIL polarity_level got clean=%b other_pulses=%0d expected clean=1 other_pulses=0",
               clean_p, dcount);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_double();
    test_triple();
    test_reset_mid_press();
    test_polarity();
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
